// File: rtl/irq_pkg.sv
// Shared widths and types for the interrupt pending front-end.
package irq_pkg;
  localparam int N_SRC = 8;
  localparam int ID_W  = 3;

  typedef enum logic {IDLE, PRESENT} irq_state_t;
  typedef logic [N_SRC-1:0] irq_vec_t;
endpackage

// File: rtl/sync_edge_det.sv
// Purpose: multi-flop synchroniser for one async line plus rising-edge or level set event.
// Latency: event asserted SYNC_STAGES clocks after the line is first sampled high.
// Backpressure: none; the event is a free-running strobe/level.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2,
  parameter bit EDGE_MODE   = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic evt
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      s_d    <= sync_q[SYNC_STAGES-1];
    end
  end

  assign evt = EDGE_MODE ? (sync_q[SYNC_STAGES-1] & ~s_d) : sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/irq_pending_ctrl.sv
// Purpose: sticky pending/overrun capture, masking toward the external encoder, id presentation.
// Latency: SYNC_STAGES+2 clocks from a raw request to irq_valid when idle and unmasked.
// Backpressure: irq_id is held until irq_ack; new requests keep accumulating as pending bits.
module irq_pending_ctrl import irq_pkg::*; #(
  parameter int SYNC_STAGES = 2,
  parameter bit EDGE_MODE   = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq_in,
  input  logic [N_SRC-1:0] irq_mask,
  output logic [N_SRC-1:0] pend_vec,
  input  logic [ID_W-1:0]  enc_idx,
  output logic             irq_valid,
  output logic [ID_W-1:0]  irq_id,
  input  logic             irq_ack,
  output logic [N_SRC-1:0] overrun
);

  irq_vec_t        set_evt;
  irq_vec_t        pending;
  irq_vec_t        clr_vec;
  irq_vec_t        ovr_set;
  irq_state_t      state, state_nxt;
  logic [ID_W-1:0] id_nxt;

  for (genvar i = 0; i < N_SRC; i++) begin : g_src
    sync_edge_det #(
      .SYNC_STAGES (SYNC_STAGES),
      .EDGE_MODE   (EDGE_MODE)
    ) u_sync (
      .clk (clk),
      .rst (rst),
      .din (irq_in[i]),
      .evt (set_evt[i])
    );
  end

  always_comb begin
    clr_vec = '0;
    if (state == PRESENT && irq_ack) clr_vec[irq_id] = 1'b1;
  end

  // A set event coinciding with the clear wins and is not an overrun.
  assign ovr_set = EDGE_MODE ? (set_evt & pending & ~clr_vec) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
      overrun <= '0;
    end else begin
      pending <= (pending & ~clr_vec) | set_evt;
      overrun <= (overrun & ~clr_vec) | ovr_set;
    end
  end

  assign pend_vec  = pending & ~irq_mask;
  assign irq_valid = (state == PRESENT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      irq_id <= '0;
    end else begin
      state  <= state_nxt;
      irq_id <= id_nxt;
    end
  end

  // The encoder reports 0 for an empty vector, so capture only when something is exposed.
  always_comb begin
    state_nxt = state;
    id_nxt    = irq_id;
    case (state)
      IDLE: begin
        if (|pend_vec) begin
          id_nxt    = enc_idx;
          state_nxt = PRESENT;
        end
      end
      PRESENT: begin
        if (irq_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Bench for irq_pending_ctrl: an edge-mode and a level-mode instance against a sample-history model.
module tb_irq_pending_ctrl;
  import irq_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] irq_in_v [2];
  logic [7:0] mask_v   [2];
  logic [7:0] pend_v   [2];
  logic [7:0] ovr_v    [2];
  logic [2:0] enc_v    [2];
  logic [2:0] id_v     [2];
  logic       ack_v    [2];
  logic       vld_v    [2];

  int n_chk  = 0;
  int n_fail = 0;

  // model state: index 0 = edge-mode instance, 1 = level-mode instance
  logic [7:0] m_pend [2];
  logic [7:0] m_ovr  [2];
  int         m_pres [2];
  logic [2:0] m_last [2];
  logic [7:0] m_hist [2][4];

  always #5 clk = ~clk;

  function automatic int hi_idx(input logic [7:0] v);
    int r = 0;
    for (int i = 0; i < 8; i++) if (v[i]) r = i;
    return r;
  endfunction

  // stand-in for the external priority encoder
  assign enc_v[0] = 3'(hi_idx(pend_v[0]));
  assign enc_v[1] = 3'(hi_idx(pend_v[1]));

  irq_pending_ctrl #(.SYNC_STAGES(2), .EDGE_MODE(1'b1)) dut (
    .clk(clk), .rst(rst), .irq_in(irq_in_v[0]), .irq_mask(mask_v[0]),
    .pend_vec(pend_v[0]), .enc_idx(enc_v[0]), .irq_valid(vld_v[0]),
    .irq_id(id_v[0]), .irq_ack(ack_v[0]), .overrun(ovr_v[0]));

  irq_pending_ctrl #(.SYNC_STAGES(2), .EDGE_MODE(1'b0)) dut_lvl (
    .clk(clk), .rst(rst), .irq_in(irq_in_v[1]), .irq_mask(mask_v[1]),
    .pend_vec(pend_v[1]), .enc_idx(enc_v[1]), .irq_valid(vld_v[1]),
    .irq_id(id_v[1]), .irq_ack(ack_v[1]), .overrun(ovr_v[1]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_pend[m] = '0;
      m_ovr[m]  = '0;
      m_pres[m] = -1;
      m_last[m] = '0;
      for (int j = 0; j < 4; j++) m_hist[m][j] = '0;
    end
  endtask

  // Synced line at edge n is the raw sample from edge n-2; the edge reference is n-3.
  task automatic model_step();
    logic [7:0] evt, clr, s, sd;
    if (rst) begin
      model_reset();
      return;
    end
    for (int m = 0; m < 2; m++) begin
      s   = m_hist[m][1];
      sd  = m_hist[m][2];
      evt = (m == 0) ? (s & ~sd) : s;
      clr = '0;
      if (m_pres[m] >= 0) begin
        if (ack_v[m]) begin
          clr[m_pres[m]] = 1'b1;
          m_pres[m] = -1;
        end
      end else if ((m_pend[m] & ~mask_v[m]) != 8'h00) begin
        m_pres[m] = hi_idx(m_pend[m] & ~mask_v[m]);
        m_last[m] = 3'(m_pres[m]);
      end
      m_ovr[m]  = (m_ovr[m] & ~clr) | ((m == 0) ? (evt & m_pend[m] & ~clr) : 8'h00);
      m_pend[m] = (m_pend[m] & ~clr) | evt;
      m_hist[m][3] = m_hist[m][2];
      m_hist[m][2] = m_hist[m][1];
      m_hist[m][1] = m_hist[m][0];
      m_hist[m][0] = irq_in_v[m];
    end
  endtask

  task automatic check_all();
    for (int m = 0; m < 2; m++) begin
      check($sformatf("vld[%0d]", m),  {31'd0, vld_v[m]}, {31'd0, m_pres[m] >= 0});
      check($sformatf("id[%0d]", m),   {29'd0, id_v[m]},  {29'd0, m_last[m]});
      check($sformatf("pend[%0d]", m), {24'd0, pend_v[m]}, {24'd0, m_pend[m] & ~mask_v[m]});
      check($sformatf("ovr[%0d]", m),  {24'd0, ovr_v[m]},  {24'd0, m_ovr[m]});
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic wait_vld(input int m, output int n);
    n = 0;
    while (!vld_v[m] && n < 20) begin
      cycle();
      n++;
    end
    check($sformatf("wait_vld[%0d]", m), {31'd0, vld_v[m]}, 32'd1);
  endtask

  task automatic ack_pulse(input int m);
    ack_v[m] = 1'b1;
    cycle();
    ack_v[m] = 1'b0;
  endtask

  int n;
  int cnt;

  initial begin
    rst = 1'b1;
    for (int m = 0; m < 2; m++) begin
      irq_in_v[m] = '0;
      mask_v[m]   = '0;
      ack_v[m]    = 1'b0;
    end
    model_reset();
    #1;
    check("rst_vld", {31'd0, vld_v[0]}, 32'd0);
    check("rst_id",  {29'd0, id_v[0]},  32'd0);
    repeat (2) cycle();
    rst = 1'b0;
    repeat (2) cycle();

    // single request: latency and clear on ack
    irq_in_v[0][5] = 1'b1;
    wait_vld(0, n);
    check("t2_latency", n, 4);
    check("t2_id", {29'd0, id_v[0]}, 32'd5);
    irq_in_v[0][5] = 1'b0;
    ack_pulse(0);
    check("t2_vld_after_ack", {31'd0, vld_v[0]}, 32'd0);
    check("t2_pend5", {31'd0, pend_v[0][5]}, 32'd0);

    // simultaneous requests: highest index first
    irq_in_v[0] = 8'h44;
    wait_vld(0, n);
    check("t3_first", {29'd0, id_v[0]}, 32'd6);
    ack_pulse(0);
    wait_vld(0, n);
    check("t3_second", {29'd0, id_v[0]}, 32'd2);
    ack_pulse(0);
    cycle();
    check("t3_idle", {31'd0, vld_v[0]}, 32'd0);
    irq_in_v[0] = '0;
    repeat (4) cycle();

    // masked source still captured; exposed after unmask
    mask_v[0]   = 8'h40;
    irq_in_v[0] = 8'h44;
    wait_vld(0, n);
    check("t4_masked_first", {29'd0, id_v[0]}, 32'd2);
    ack_v[0] = 1'b1;
    cycle();
    ack_v[0]  = 1'b0;
    mask_v[0] = '0;
    wait_vld(0, n);
    check("t4_unmask_lat", {31'd0, n <= 2}, 32'd1);
    check("t4_id6", {29'd0, id_v[0]}, 32'd6);
    ack_pulse(0);
    irq_in_v[0] = '0;
    repeat (4) cycle();

    // overrun on a second edge while pending
    irq_in_v[0][3] = 1'b1;
    wait_vld(0, n);
    irq_in_v[0][3] = 1'b0;
    repeat (2) cycle();
    irq_in_v[0][3] = 1'b1;
    repeat (4) cycle();
    check("t5_ovr_set", {31'd0, ovr_v[0][3]}, 32'd1);
    ack_pulse(0);
    check("t5_ovr_clr", {31'd0, ovr_v[0][3]}, 32'd0);
    irq_in_v[0][3] = 1'b0;
    repeat (3) cycle();
    // edge landing on the ack edge: set wins, no overrun
    irq_in_v[0][3] = 1'b1;
    wait_vld(0, n);
    irq_in_v[0][3] = 1'b0;
    repeat (2) cycle();
    irq_in_v[0][3] = 1'b1;
    repeat (2) cycle();
    ack_pulse(0);
    check("t5_set_wins", {31'd0, pend_v[0][3]}, 32'd1);
    check("t5_no_ovr", {31'd0, ovr_v[0][3]}, 32'd0);
    cycle();
    check("t5_repres_vld", {31'd0, vld_v[0]}, 32'd1);
    check("t5_repres_id", {29'd0, id_v[0]}, 32'd3);
    ack_pulse(0);
    irq_in_v[0] = '0;
    repeat (3) cycle();

    // level mode with request and ack both held high
    irq_in_v[1][1] = 1'b1;
    wait_vld(1, n);
    check("t6_latency", n, 4);
    ack_v[1] = 1'b1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (vld_v[1]) cnt++;
    end
    check("t6_repres", cnt, 3);
    check("t6_id", {29'd0, id_v[1]}, 32'd1);
    check("t6_no_ovr", {24'd0, ovr_v[1]}, 32'd0);
    irq_in_v[1] = '0;
    repeat (6) cycle();
    ack_v[1] = 1'b0;
    cycle();

    // asynchronous reset mid-presentation
    irq_in_v[0] = 8'hA5;
    irq_in_v[1] = 8'hA5;
    wait_vld(0, n);
    check("t1_pend", {24'd0, pend_v[0]}, 32'hA5);
    #2 rst = 1'b1;
    #1;
    for (int m = 0; m < 2; m++) begin
      check($sformatf("t1_vld[%0d]", m),  {31'd0, vld_v[m]}, 32'd0);
      check($sformatf("t1_pend[%0d]", m), {24'd0, pend_v[m]}, 32'd0);
      check($sformatf("t1_ovr[%0d]", m),  {24'd0, ovr_v[m]},  32'd0);
      check($sformatf("t1_id[%0d]", m),   {29'd0, id_v[m]},   32'd0);
    end
    cycle();
    irq_in_v[0] = '0;
    irq_in_v[1] = '0;
    rst = 1'b0;
    repeat (3) cycle();

    // randomized traffic, masks, acks and occasional resets
    for (int k = 0; k < 1500; k++) begin
      for (int m = 0; m < 2; m++) begin
        irq_in_v[m] ^= 8'($urandom & $urandom & $urandom);
        if ($urandom_range(0, 15) == 0) mask_v[m] = 8'($urandom & $urandom);
        ack_v[m] = 1'($urandom_range(0, 1));
      end
      rst = ($urandom_range(0, 199) == 0);
      cycle();
    end
    rst = 1'b0;
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
